calc_multi: RTL and testbench
=============================

Name: calc_multi

Overview:
- Parametrised successor of the single-operation keypad calculator.
- Decimal operand entry with backspace; add, subtract, multiply (shift-add) and divide (restoring).
- Results chain as the next first operand.
- Continuously scanned decimal display of NDIG digits, explicit command-valid handshake and defined overflow/error handling.

Parameters:
- NDIG, 8: number of decimal display digits; operands and results limited to 10^NDIG-1.
- W, 27: datapath width in bits; must satisfy 2^W > 10^NDIG-1; also the mul/div iteration count.
- POSW, 4: width of pos output; must satisfy 2^POSW >= NDIG.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd  in  4  keypad code:
  - 0-9: digit
  - 1010: add
  - 1011: sub
  - 1100: mul
  - 1101: div
  - 1110: equals/clear
  - 1111: backspace
- cmd_valid  in  1  one-cycle strobe qualifying cmd.
- status  out  2  00 error, 01 busy, 10 ready.
- data  out  4  decimal digit currently driven; 4'hA is minus sign (only with CALC_NEG_EN).
- pos  out  POSW  display position of data; 0 is least significant.

Behaviour:
- Reset (reset=0): state ENTRY_A, acc=regA=regB=op=0, fresh=0, status=10, pos=0, data=0. Reset mid-operation aborts immediately.
- A command is accepted only when cmd_valid=1 and status=10. Ignored otherwise, including during BUSY.
- States: ENTRY_A, ENTRY_B, BUSY, ERROR.
- Digit d, in ENTRY_A or ENTRY_B:
  - acc <= acc*10+d if acc < 10^(NDIG-1); else ignored (no error).
  - If fresh=1: acc <= d, fresh <= 0.
- Backspace: acc <= acc/10; fresh <= 0.
- ENTRY_A operator: regA <= acc, op <= cmd, acc <= 0, fresh <= 0, go ENTRY_B. Equals in ENTRY_A is ignored.
- ENTRY_B:
  - Equals: regB <= acc, go BUSY.
  - Operator: go ERROR.
- BUSY: status=01; data=0.
  - N=1 cycle for add/sub; N=W cycles for mul/div.
  - Equals accepted at edge T: status=01 for T+1..T+N; result in acc, status=10, state ENTRY_A, fresh=1 at T+N+1.
- Arithmetic: unsigned, W bits.
  - Mul: product > 10^NDIG-1, or any intermediate carry beyond W, -> ERROR.
  - Sub: regA < regB -> ERROR.
  - Div: quotient only, remainder discarded; regB=0 -> ERROR detected on the first BUSY cycle.
- ERROR: status=00, acc=0, all digits display 0. Equals clears all registers and returns to ENTRY_A, status=10. Other commands are ignored.
- Display:
  - pos free-runs 0,1,..,NDIG-1,0 every cycle in all states.
  - data = decimal digit pos of acc (combinational, same cycle as pos). Leading zeros shown as 0.

Optional Feature:
- Macro: CALC_NEG_EN.
- Defined: sub with regA < regB yields the magnitude regB-regA in acc plus a neg flag.
  - data=4'hA at pos=NDIG-1; magnitude shown in the lower NDIG-1 digits.
  - neg is cleared by the next digit, operator or reset.
  - A negative result used as regA is treated as its magnitude.
- Undefined: regA < regB -> ERROR.

Test Plan:
- Keys 1,2,add,3,4,equals -> status 01 exactly 1 cycle, then 10; acc=46; pos0 data=6, pos1 data=4, pos2..7 data=0.
- Keys 1,2,3,backspace,mul,7,equals -> status 01 for 27 cycles, then 10; display 84. Next key 5 -> display 5 (fresh entry). Chaining instead with add,1,equals -> 85.
- Keys 5,sub,9,equals:
  - without CALC_NEG_EN -> status 00, all digits 0.
  - with CALC_NEG_EN -> status 10, pos0 data=4, pos7 data=4'hA.
- Keys 9,div,0,equals -> status 00. Then equals -> status 10, acc=0. Keys 1,0,0,div,7,equals -> display 14.
- Nine keys 9 -> acc=99999999 (ninth ignored). Then mul,2,equals -> status 00. Any cmd_valid strobe during busy cycles is ignored.
- Keys 6,mul,6,equals, then reset low on the 5th busy cycle -> status=10, pos=0, data=0 immediately. After release, keys 3,add,4,equals -> 7.

Source files
------------

// File: rtl/calc_multi.sv
// Keypad calculator: decimal entry with backspace, add/sub/mul/div with chaining,
// scanned NDIG-digit display. Define CALC_NEG_EN to allow negative subtraction results.
module calc_multi #(
  parameter int NDIG = 8,
  parameter int W    = 27,
  parameter int POSW = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      cmd,
  input  logic            cmd_valid,
  output logic [1:0]      status,
  output logic [3:0]      data,
  output logic [POSW-1:0] pos
);

  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, BUSY, ERROR} state_t;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;
  localparam logic [3:0] K_EQ   = 4'hE;
  localparam logic [3:0] K_BS   = 4'hF;

  localparam logic [W-1:0] MAXV = W'(10**NDIG - 1);
  localparam logic [W-1:0] LIM  = W'(10**(NDIG-1));
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t state, state_next;
  logic [W-1:0] acc, reg_a, reg_b, work, rem, sh;
  logic [3:0] op;
  logic fresh, ovf, neg;
  logic [CW-1:0] cnt;

  logic accept, is_digit, is_op, is_eq, is_bs;
  logic [W+1:0] mul_t;
  logic [W:0] div_r, add_s;
  logic div_ge;
  logic [W-1:0] div_rem, result;
  logic busy_last, busy_err;
`ifdef CALC_NEG_EN
  logic neg_res;
`endif

  assign accept   = cmd_valid && (state == ENTRY_A || state == ENTRY_B);
  assign is_digit = cmd <= 4'd9;
  assign is_op    = cmd >= OP_ADD && cmd <= OP_DIV;
  assign is_eq    = cmd == K_EQ;
  assign is_bs    = cmd == K_BS;

  // MSB-first shift-add; two spare bits catch any carry beyond W.
  assign mul_t   = {1'b0, work, 1'b0} + (sh[W-1] ? {2'b00, reg_a} : {(W+2){1'b0}});
  // Restoring division step on the next dividend bit.
  assign div_r   = {rem, sh[W-1]};
  assign div_ge  = div_r >= {1'b0, reg_b};
  assign div_rem = div_ge ? W'(div_r - {1'b0, reg_b}) : div_r[W-1:0];
  assign add_s   = {1'b0, reg_a} + {1'b0, reg_b};

  always_comb begin
    busy_last = 1'b0;
    busy_err  = 1'b0;
    result    = '0;
`ifdef CALC_NEG_EN
    neg_res   = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        busy_last = 1'b1;
        result    = add_s[W-1:0];
        busy_err  = add_s > {1'b0, MAXV};
      end
      OP_SUB: begin
        busy_last = 1'b1;
        if (reg_a >= reg_b) begin
          result = reg_a - reg_b;
        end else begin
`ifdef CALC_NEG_EN
          result  = reg_b - reg_a;
          neg_res = 1'b1;
`else
          busy_err = 1'b1;
`endif
        end
      end
      OP_MUL: begin
        busy_last = cnt == LAST;
        result    = mul_t[W-1:0];
        busy_err  = busy_last && (ovf || mul_t > {2'b00, MAXV});
      end
      OP_DIV: begin
        if (reg_b == '0) begin
          busy_last = 1'b1;
          busy_err  = 1'b1;
        end else begin
          busy_last = cnt == LAST;
          result    = {work[W-2:0], div_ge};
        end
      end
      default: busy_last = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ENTRY_A;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    status     = 2'b10;
    case (state)
      ENTRY_A: if (accept && is_op) state_next = ENTRY_B;
      ENTRY_B: begin
        if (accept && is_eq)      state_next = BUSY;
        else if (accept && is_op) state_next = ERROR;
      end
      BUSY: begin
        status = 2'b01;
        if (busy_err)       state_next = ERROR;
        else if (busy_last) state_next = ENTRY_A;
      end
      ERROR: begin
        status = 2'b00;
        if (cmd_valid && is_eq) state_next = ENTRY_A;
      end
      default: state_next = ENTRY_A;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      reg_a <= '0;
      reg_b <= '0;
      op    <= '0;
      fresh <= 1'b0;
      work  <= '0;
      rem   <= '0;
      sh    <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ENTRY_A, ENTRY_B: begin
          if (accept) begin
            if (is_digit) begin
              if (fresh) begin
                acc   <= W'(cmd);
                fresh <= 1'b0;
              end else if (acc < LIM) begin
                acc <= acc * W'(10) + W'(cmd);
              end
            end else if (is_bs) begin
              acc   <= acc / W'(10);
              fresh <= 1'b0;
            end else if (is_op) begin
              acc   <= '0;
              fresh <= 1'b0;
              if (state == ENTRY_A) begin
                reg_a <= acc;
                op    <= cmd;
              end
            end else if (state == ENTRY_B) begin
              // Multiplier bits feed the shifter for mul, dividend bits for div.
              reg_b <= acc;
              cnt   <= '0;
              work  <= '0;
              rem   <= '0;
              ovf   <= 1'b0;
              sh    <= (op == OP_MUL) ? acc : reg_a;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          sh  <= sh << 1;
          if (op == OP_MUL) begin
            work <= mul_t[W-1:0];
            if (mul_t[W+1:W] != 2'b00) ovf <= 1'b1;
          end else begin
            work <= {work[W-2:0], div_ge};
            rem  <= div_rem;
          end
          if (busy_err) begin
            acc <= '0;
          end else if (busy_last) begin
            acc   <= result;
            fresh <= 1'b1;
          end
        end
        ERROR: begin
          if (cmd_valid && is_eq) begin
            acc   <= '0;
            reg_a <= '0;
            reg_b <= '0;
            op    <= '0;
            fresh <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CALC_NEG_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg <= 1'b0;
    end else if (state == BUSY) begin
      if (busy_err)       neg <= 1'b0;
      else if (busy_last) neg <= neg_res;
    end else if (accept && (is_digit || is_op)) begin
      neg <= 1'b0;
    end
  end
`else
  assign neg = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                         pos <= '0;
    else if (pos == POSW'(NDIG - 1))    pos <= '0;
    else                                pos <= pos + 1'b1;
  end

  // Per-position decimal digits of acc, muxed by the scan position.
  logic [W-1:0] quo   [NDIG];
  logic [3:0]   digit [NDIG];
  logic [3:0]   sel;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      assign quo[gi]   = acc / W'(10**gi);
      assign digit[gi] = 4'(quo[gi] % W'(10));
    end
  endgenerate

  always_comb begin
    sel = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (pos == POSW'(i)) sel = digit[i];
    end
    if (state == BUSY)                        data = 4'd0;
    else if (neg && pos == POSW'(NDIG - 1))   data = 4'hA;
    else                                      data = sel;
  end

endmodule

// File: tb/tb_calc_multi.sv
// Scoreboard bench for calc_multi: a queue-based reference model predicts busy lengths
// and displayed values; a negedge monitor checks them as the DUT presents them.
module tb_calc_multi;
  localparam int NDIG = 8;
  localparam int W    = 27;
  localparam int POSW = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      cmd = 4'd0;
  logic            cmd_valid = 1'b0;
  logic [1:0]      status;
  logic [3:0]      data;
  logic [POSW-1:0] pos;

  calc_multi #(.NDIG(NDIG), .W(W), .POSW(POSW)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .status(status), .data(data), .pos(pos)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] st;
    longint     val;
    bit         neg;
  } disp_t;

  disp_t q_disp[$];
  int    q_busy[$];

  // Reference model: 0 = operand A entry, 1 = operand B entry, 2 = error
  int         m_state = 0;
  longint     m_acc = 0, m_a = 0, m_b = 0;
  logic [3:0] m_op = 4'd0;
  bit         m_fresh = 0, m_neg = 0;

  function automatic longint p10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_acc = 0; m_a = 0; m_b = 0; m_op = 4'd0; m_fresh = 0; m_neg = 0;
  endfunction

  // Returns the expected number of busy cycles (0 if the key starts no operation).
  function automatic int model_apply(input logic [3:0] c);
    int     len;
    bit     err;
    bit     ng;
    longint r;
    longint maxv;
    len = 0; err = 0; ng = 0; r = 0;
    maxv = p10(NDIG) - 1;
    if (m_state == 2) begin
      if (c == 4'hE) model_reset();
      return 0;
    end
    if (c <= 4'd9) begin
      m_neg = 0;
      if (m_fresh) begin
        m_acc = longint'(c);
        m_fresh = 0;
      end else if (m_acc < p10(NDIG-1)) begin
        m_acc = m_acc * 10 + longint'(c);
      end
    end else if (c == 4'hF) begin
      m_acc = m_acc / 10;
      m_fresh = 0;
    end else if (c != 4'hE) begin
      m_neg = 0;
      m_fresh = 0;
      if (m_state == 0) begin
        m_a = m_acc; m_op = c; m_acc = 0; m_state = 1;
      end else begin
        m_acc = 0; m_state = 2;
      end
    end else if (m_state == 1) begin
      m_b = m_acc;
      case (m_op)
        4'hA: begin len = 1; r = m_a + m_b; err = r > maxv; end
        4'hB: begin
          len = 1;
          if (m_a >= m_b) r = m_a - m_b;
          else begin
`ifdef CALC_NEG_EN
            r = m_b - m_a; ng = 1;
`else
            err = 1;
`endif
          end
        end
        4'hC: begin len = W; r = m_a * m_b; err = r > maxv; end
        default: begin
          if (m_b == 0) begin len = 1; err = 1; end
          else begin len = W; r = m_a / m_b; end
        end
      endcase
      if (err) begin
        m_state = 2; m_acc = 0; m_neg = 0;
      end else begin
        m_state = 0; m_acc = r; m_fresh = 1; m_neg = ng;
      end
    end
    return len;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 200 && status == 2'b01; i++) @(negedge clock);
    checks++;
    if (status == 2'b01) begin
      errors++;
      $display("FAIL busy_timeout: status=%b still busy, required leave busy within 200 cycles", status);
    end
  endtask

  task automatic push_check();
    disp_t e;
    e.st  = (m_state == 2) ? 2'b00 : 2'b10;
    e.val = m_acc;
    e.neg = m_neg;
    q_disp.push_back(e);
    for (int i = 0; i < 4 * NDIG && q_disp.size() > 0; i++) @(negedge clock);
    if (q_disp.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL display_timeout: no full scan observed, required one within %0d cycles", 4 * NDIG);
      void'(q_disp.pop_front());
    end
  endtask

  task automatic send_key(input logic [3:0] c, input bit noisy);
    int len;
    @(negedge clock);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    len = model_apply(c);
    if (len > 0) begin
      q_busy.push_back(len);
      if (noisy && len > 2) begin
        for (int k = 0; k < len - 2; k++) begin
          cmd = 4'($urandom_range(0, 15));
          cmd_valid = 1'($urandom_range(0, 1));
          @(negedge clock);
        end
        cmd_valid = 1'b0;
      end
    end
    wait_idle();
    push_check();
  endtask

  task automatic keys(input string s, input bit noisy);
    logic [3:0] c;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "+": c = 4'hA;
        "-": c = 4'hB;
        "*": c = 4'hC;
        "/": c = 4'hD;
        "=": c = 4'hE;
        "<": c = 4'hF;
        default: c = 4'(s[i] - "0");
      endcase
      send_key(c, noisy);
    end
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Monitor: pos sequencing, busy-period length, and full-scan display frames.
  logic [3:0]      frame [NDIG];
  bit              collecting = 0;
  int              busy_cnt = 0;
  logic [POSW-1:0] prev_pos = '0;

  always @(negedge clock) begin
    if (!reset) begin
      busy_cnt   = 0;
      collecting = 0;
      prev_pos   = '0;
    end else begin
      checks++;
      if (int'(pos) != (int'(prev_pos) + 1) % NDIG) begin
        errors++;
        $display("FAIL pos_seq: got pos=%0d after %0d, required %0d", pos, prev_pos,
                 (int'(prev_pos) + 1) % NDIG);
      end
      prev_pos = pos;

      if (status == 2'b01) begin
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        checks++;
        if (q_busy.size() == 0) begin
          errors++;
          $display("FAIL busy_len: unexpected busy period of %0d cycles, required none", busy_cnt);
        end else begin
          int e;
          e = q_busy.pop_front();
          if (busy_cnt != e) begin
            errors++;
            $display("FAIL busy_len: got %0d busy cycles, required %0d", busy_cnt, e);
          end
        end
        busy_cnt = 0;
      end

      if (!collecting && status != 2'b01 && pos == '0 && q_disp.size() > 0) collecting = 1;
      if (collecting) begin
        frame[int'(pos)] = data;
        if (int'(pos) == NDIG - 1) begin
          disp_t  e;
          longint low, exp_low;
          logic [3:0] exp_top;
          bit     ok;
          e = q_disp.pop_front();
          low = 0;
          ok = 1;
          for (int i = NDIG - 2; i >= 0; i--) begin
            low = low * 10 + longint'(frame[i]);
            if (frame[i] > 4'd9) ok = 0;
          end
          exp_low = e.val % p10(NDIG - 1);
          exp_top = e.neg ? 4'hA : 4'(e.val / p10(NDIG - 1));
          if (status != e.st || low != exp_low || frame[NDIG-1] != exp_top) ok = 0;
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL display: got status=%b top=%h low=%0d, required status=%b top=%h low=%0d",
                     status, frame[NDIG-1], low, e.st, exp_top, exp_low);
          end
          collecting = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c;
    int r;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_status", longint'(status), 2);
    chk("reset_pos", longint'(pos), 0);
    chk("reset_data", longint'(data), 0);
    #2 reset = 1'b1;
    push_check();

    keys("12+34=", 1'b0);
    keys("123<*7=", 1'b1);
    keys("5", 1'b0);
    keys("<123<*7=+1=", 1'b0);
    keys("5-9=", 1'b0);
    keys("=", 1'b0);
    keys("9/0==", 1'b0);
    keys("100/7=", 1'b0);
    keys("999999999*2=", 1'b1);
    keys("=", 1'b0);

    // Abort a multiply with reset on its fifth busy cycle.
    keys("6*6", 1'b0);
    @(negedge clock);
    cmd = 4'hE;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort_busy_before", longint'(status), 1);
    #1 reset = 1'b0;
    #1;
    chk("abort_status", longint'(status), 2);
    chk("abort_pos", longint'(pos), 0);
    chk("abort_data", longint'(data), 0);
    model_reset();
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    keys("3+4=", 1'b0);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      c = 4'($urandom_range(0, 9));
      else if (r < 70) c = 4'($urandom_range(10, 13));
      else if (r < 85) c = 4'hE;
      else             c = 4'hF;
      send_key(c, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clock);
    chk("busy_queue_drained", longint'(q_busy.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
